// File: rtl/execution_stage.sv
// EX stage of the 5-stage MIPS pipeline: combinational ALU/address result, HI/LO
// registers and a fixed-latency multiply/divide unit that reports when it is busy.
module execution_stage #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Inst,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  input  logic [31:0] immediate,
  input  logic [31:0] DO,
  input  logic        DO_reliable,
  output logic [31:0] Inst_out,
  output logic [31:0] rt_out,
  output logic [31:0] AO,
  output logic        Multiply_busy
);

  localparam int CMAX = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);

  logic [5:0]    op;
  logic [5:0]    funct;
  logic [4:0]    shamt;
  logic          is_start;
  logic          start_go;
  logic          is_mthi;
  logic          is_mtlo;
  logic [31:0]   alu;

  logic [31:0]   hi;
  logic [31:0]   lo;
  logic [CW-1:0] cnt;
  logic [1:0]    kind;
  logic [31:0]   opa;
  logic [31:0]   opb;

  logic [63:0]   prod;
  logic          neg_a;
  logic          neg_b;
  logic [31:0]   mag_a;
  logic [31:0]   mag_b;
  logic [31:0]   q_mag;
  logic [31:0]   r_mag;
  logic [31:0]   div_q;
  logic [31:0]   div_r;

  assign op    = Inst[31:26];
  assign funct = Inst[5:0];
  assign shamt = Inst[10:6];

  // mult/multu/div/divu share funct 0110xx; funct[1] selects divide, funct[0] unsigned
  assign is_start = (op == 6'b000000) && (funct[5:2] == 4'b0110);
  assign start_go = is_start && (cnt == '0);
  assign is_mthi  = (op == 6'b000000) && (funct == 6'b010001);
  assign is_mtlo  = (op == 6'b000000) && (funct == 6'b010011);

  always_comb begin
    alu = '0;
    if (op == 6'b000000) begin
      case (funct)
        6'b100000, 6'b100001: alu = rs + rt;
        6'b100010, 6'b100011: alu = rs - rt;
        6'b100100: alu = rs & rt;
        6'b100101: alu = rs | rt;
        6'b100110: alu = rs ^ rt;
        6'b100111: alu = ~(rs | rt);
        6'b101010: alu = {31'b0, $signed(rs) < $signed(rt)};
        6'b101011: alu = {31'b0, rs < rt};
        6'b000000: alu = rt << shamt;
        6'b000010: alu = rt >> shamt;
        6'b000011: alu = $unsigned($signed(rt) >>> shamt);
        6'b000100: alu = rt << rs[4:0];
        6'b000110: alu = rt >> rs[4:0];
        6'b000111: alu = $unsigned($signed(rt) >>> rs[4:0]);
        6'b010000: alu = hi;
        6'b010010: alu = lo;
        default:   alu = '0;
      endcase
    end else if (op[5]) begin
      alu = rs + immediate;
    end else begin
      case (op)
        6'b001000, 6'b001001: alu = rs + immediate;
        6'b001010: alu = {31'b0, $signed(rs) < $signed(immediate)};
        6'b001011: alu = {31'b0, rs < immediate};
        6'b001100: alu = rs & immediate;
        6'b001101: alu = rs | immediate;
        6'b001110: alu = rs ^ immediate;
        6'b001111: alu = {immediate[15:0], 16'b0};
        default:   alu = '0;
      endcase
    end
  end

  // Divide works on magnitudes so the quotient truncates toward zero and the
  // remainder follows the dividend's sign.
  always_comb begin
    if (kind[0]) prod = {32'b0, opa} * {32'b0, opb};
    else         prod = {{32{opa[31]}}, opa} * {{32{opb[31]}}, opb};
    neg_a = ~kind[0] & opa[31];
    neg_b = ~kind[0] & opb[31];
    mag_a = neg_a ? -opa : opa;
    mag_b = neg_b ? -opb : opb;
    q_mag = mag_a / mag_b;
    r_mag = mag_a % mag_b;
    div_q = (neg_a ^ neg_b) ? -q_mag : q_mag;
    div_r = neg_a ? -r_mag : r_mag;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi   <= '0;
      lo   <= '0;
      cnt  <= '0;
      kind <= '0;
      opa  <= '0;
      opb  <= '0;
    end else begin
      if (start_go) begin
        cnt  <= funct[1] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
        kind <= funct[1:0];
        opa  <= rs;
        opb  <= rt;
      end else if (cnt != '0) begin
        cnt <= cnt - CW'(1);
        if (cnt == CW'(1)) begin
          if (!kind[1]) begin
            hi <= prod[63:32];
            lo <= prod[31:0];
          end else if (opb != '0) begin
            hi <= div_r;
            lo <= div_q;
          end
        end
      end
      if (is_mthi) hi <= rs;
      if (is_mtlo) lo <= rs;
    end
  end

  assign Inst_out      = Inst;
  assign rt_out        = rt;
  assign AO            = DO_reliable ? DO : alu;
  // Gated by reset so busy drops the moment reset asserts, even with a start in EX.
  assign Multiply_busy = reset & (is_start | (cnt != '0));

endmodule

// File: tb/tb_execution_stage.sv
// Testbench for execution_stage: directed corner cases plus randomized instruction
// streams compared against a cycle-level HI/LO reference model.
module tb_execution_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] inst = '0, rs = '0, rt = '0, imm = '0, do_v = '0;
  logic        dor = 1'b0;
  logic [31:0] inst_out, rt_out, ao;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  logic [31:0] m_hi = '0, m_lo = '0;
  logic [31:0] p_hi = '0, p_lo = '0;
  logic        p_valid = 1'b0;
  int          m_rem = 0;

  logic [31:0] last_ao;
  logic        last_busy;

  logic [5:0] alu_fn [16] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                              6'h2a, 6'h2b, 6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07};
  logic [5:0] i_ops  [14] = '{6'h08, 6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0d, 6'h0e, 6'h0f,
                              6'h23, 6'h2b, 6'h20, 6'h28, 6'h02, 6'h04};
  logic [5:0] hl_fn  [8]  = '{6'h18, 6'h19, 6'h1a, 6'h1b, 6'h10, 6'h12, 6'h11, 6'h13};

  execution_stage dut (
    .clk(clk), .reset(reset), .Inst(inst), .rs(rs), .rt(rt), .immediate(imm),
    .DO(do_v), .DO_reliable(dor), .Inst_out(inst_out), .rt_out(rt_out), .AO(ao),
    .Multiply_busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] r_inst(input logic [5:0] fn, input logic [4:0] sh);
    return {6'b0, 15'd0, sh, fn};
  endfunction

  function automatic logic [31:0] i_inst(input logic [5:0] opc);
    return {opc, 26'd0};
  endfunction

  function automatic logic is_start_f(input logic [31:0] in);
    return (in[31:26] == 6'd0) && (in[5:0] >= 6'h18) && (in[5:0] <= 6'h1b);
  endfunction

  function automatic logic [31:0] ref_ao(input logic [31:0] in, input logic [31:0] a,
                                         input logic [31:0] b, input logic [31:0] im,
                                         input logic [31:0] d, input logic dr);
    logic [5:0] opc;
    logic [5:0] fn;
    int         sh;
    opc = in[31:26];
    fn  = in[5:0];
    sh  = int'(in[10:6]);
    if (dr) return d;
    if (opc == 6'd0) begin
      case (fn)
        6'h20, 6'h21: return a + b;
        6'h22, 6'h23: return a - b;
        6'h24: return a & b;
        6'h25: return a | b;
        6'h26: return a ^ b;
        6'h27: return ~(a | b);
        6'h2a: return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
        6'h2b: return (a < b) ? 32'd1 : 32'd0;
        6'h00: return b << sh;
        6'h02: return b >> sh;
        6'h03: return int'(b) >>> sh;
        6'h04: return b << a[4:0];
        6'h06: return b >> a[4:0];
        6'h07: return int'(b) >>> a[4:0];
        6'h10: return m_hi;
        6'h12: return m_lo;
        default: return 32'd0;
      endcase
    end
    if (opc[5]) return a + im;
    case (opc)
      6'h08, 6'h09: return a + im;
      6'h0a: return (int'(a) < int'(im)) ? 32'd1 : 32'd0;
      6'h0b: return (a < im) ? 32'd1 : 32'd0;
      6'h0c: return a & im;
      6'h0d: return a | im;
      6'h0e: return a ^ im;
      6'h0f: return {im[15:0], 16'h0000};
      default: return 32'd0;
    endcase
  endfunction

  // Apply one instruction for a cycle: check outputs mid-cycle, advance model at the edge.
  task automatic step(input logic [31:0] in, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] im, input logic [31:0] d, input logic dr);
    logic        st;
    logic [5:0]  fn;
    logic [63:0] pr;
    longint      sa, sb;
    inst = in; rs = a; rt = b; imm = im; do_v = d; dor = dr;
    st = is_start_f(in);
    fn = in[5:0];
    @(negedge clk);
    last_ao   = ao;
    last_busy = busy;
    check("ao", ao, ref_ao(in, a, b, im, d, dr));
    check("busy", {31'd0, busy}, {31'd0, (st || m_rem > 0)});
    check("inst_out", inst_out, in);
    check("rt_out", rt_out, b);
    @(posedge clk);
    if (st && m_rem == 0) begin
      sa = longint'(int'(a));
      sb = longint'(int'(b));
      p_valid = 1'b1;
      case (fn)
        6'h18: pr = 64'(sa * sb);
        6'h19: pr = {32'd0, a} * {32'd0, b};
        6'h1a: if (b != 0) pr = {32'(sa % sb), 32'(sa / sb)}; else p_valid = 1'b0;
        default: if (b != 0) pr = {a % b, a / b}; else p_valid = 1'b0;
      endcase
      {p_hi, p_lo} = pr;
      m_rem = fn[1] ? 10 : 5;
    end else if (m_rem > 0) begin
      m_rem--;
      if (m_rem == 0 && p_valid) begin
        m_hi = p_hi;
        m_lo = p_lo;
      end
    end
    if (in[31:26] == 6'd0 && fn == 6'h11) m_hi = a;
    if (in[31:26] == 6'd0 && fn == 6'h13) m_lo = a;
    #1;
  endtask

  task automatic nop();
    step(32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0);
  endtask

  task automatic rand_step();
    logic [31:0] in, a, b, im, r;
    int          sel;
    a   = $urandom;
    b   = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
    if ($urandom_range(0, 3) == 0) b = $urandom_range(0, 40) - 20;
    r   = $urandom;
    im  = $urandom_range(0, 1) ? {{16{r[15]}}, r[15:0]} : {16'd0, r[15:0]};
    sel = $urandom_range(0, 9);
    if (sel <= 3)      in = {6'd0, 20'($urandom), alu_fn[$urandom_range(0, 15)]};
    else if (sel <= 6) in = {i_ops[$urandom_range(0, 13)], 26'($urandom)};
    else if (m_rem > 0) in = {6'd0, 20'($urandom), hl_fn[$urandom_range(0, 3)]};
    else               in = {6'd0, 20'($urandom), hl_fn[$urandom_range(0, 7)]};
    step(in, a, b, im, $urandom, $urandom_range(0, 7) == 0);
  endtask

  initial begin
    // reset state
    inst = r_inst(6'h10, 5'd0); rt = 32'hA5A5_0001;
    #12;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_mfhi", ao, 32'd0);
    check("rst_inst_out", inst_out, r_inst(6'h10, 5'd0));
    check("rst_rt_out", rt_out, 32'hA5A5_0001);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;

    step(r_inst(6'h21, 0), 32'hFFFF_FFFF, 32'd1, 0, 0, 0);  check("addu_wrap", last_ao, 32'd0);
    step(r_inst(6'h2a, 0), 32'hFFFF_FFFF, 32'd1, 0, 0, 0);  check("slt", last_ao, 32'd1);
    step(r_inst(6'h2b, 0), 32'hFFFF_FFFF, 32'd1, 0, 0, 0);  check("sltu", last_ao, 32'd0);
    step(r_inst(6'h03, 4), 0, 32'h8000_0000, 0, 0, 0);      check("sra", last_ao, 32'hF800_0000);
    step(r_inst(6'h06, 0), 32'd4, 32'h8000_0000, 0, 0, 0);  check("srlv", last_ao, 32'h0800_0000);
    step(i_inst(6'h23), 32'h1000, 0, 32'hFFFF_FFFC, 0, 0);  check("lw_addr", last_ao, 32'h0000_0FFC);
    step(i_inst(6'h03), 0, 0, 0, 32'h3004, 1);               check("jal_do", last_ao, 32'h3004);
    step(i_inst(6'h0f), 0, 0, 32'h0000_1234, 0, 0);          check("lui", last_ao, 32'h1234_0000);

    // mult -3 * 7: busy in start cycle plus five more
    step(r_inst(6'h18, 0), 32'hFFFF_FFFD, 32'd7, 0, 0, 0);  check("mult_busy0", {31'd0, last_busy}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      nop(); check("mult_busy", {31'd0, last_busy}, 32'd1);
    end
    step(r_inst(6'h12, 0), 0, 0, 0, 0, 0); check("mult_lo", last_ao, 32'hFFFF_FFEB);
    check("mult_done", {31'd0, last_busy}, 32'd0);
    step(r_inst(6'h10, 0), 0, 0, 0, 0, 0); check("mult_hi", last_ao, 32'hFFFF_FFFF);

    // div -7 / 2, then divu by zero leaves HI/LO alone
    step(r_inst(6'h1a, 0), 32'hFFFF_FFF9, 32'd2, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      nop(); check("div_busy", {31'd0, last_busy}, 32'd1);
    end
    step(r_inst(6'h12, 0), 0, 0, 0, 0, 0); check("div_lo", last_ao, 32'hFFFF_FFFD);
    check("div_done", {31'd0, last_busy}, 32'd0);
    step(r_inst(6'h10, 0), 0, 0, 0, 0, 0); check("div_hi", last_ao, 32'hFFFF_FFFF);
    step(r_inst(6'h1b, 0), 32'd5, 32'd0, 0, 0, 0);
    for (int i = 0; i < 10; i++) nop();
    step(r_inst(6'h12, 0), 0, 0, 0, 0, 0); check("divz_lo", last_ao, 32'hFFFF_FFFD);
    step(r_inst(6'h10, 0), 0, 0, 0, 0, 0); check("divz_hi", last_ao, 32'hFFFF_FFFF);

    for (int i = 0; i < 800; i++) rand_step();
    for (int i = 0; i < 12; i++) nop();

    // reset mid-multiply discards the result and clears HI
    step(r_inst(6'h11, 0), 32'h12, 0, 0, 0, 0);
    step(r_inst(6'h10, 0), 0, 0, 0, 0, 0); check("mthi", last_ao, 32'h12);
    step(r_inst(6'h19, 0), 32'd5, 32'd6, 0, 0, 0);
    nop(); nop();
    inst = 32'd0; #2;
    reset = 1'b0; #1;
    check("rst_mid_busy", {31'd0, busy}, 32'd0);
    m_hi = '0; m_lo = '0; m_rem = 0; p_valid = 1'b0;
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    step(r_inst(6'h10, 0), 0, 0, 0, 0, 0); check("rst_mid_hi", last_ao, 32'd0);
    for (int i = 0; i < 6; i++) nop();
    step(r_inst(6'h12, 0), 0, 0, 0, 0, 0); check("rst_mid_lo", last_ao, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
